// File: rtl/bcd_calendar_counter.sv
// BCD time-of-day and calendar counter with tick prescaler, 12/24-hour
// display, leap-year February, validated parallel load and per-field pulses.
module bcd_calendar_counter #(
  parameter int unsigned DIV     = 1,
  parameter bit          LEAP_EN = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       mode24,
  input  logic       load,
  input  logic [7:0] ld_sec,
  input  logic [7:0] ld_min,
  input  logic [7:0] ld_hour,
  input  logic [7:0] ld_day,
  input  logic [7:0] ld_month,
  input  logic [7:0] ld_year,
  output logic [7:0] sec_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] hour_bcd,
  output logic [7:0] day_bcd,
  output logic [7:0] month_bcd,
  output logic [7:0] year_bcd,
  output logic       pm,
  output logic [5:0] min_bin,
  output logic [4:0] hour_bin,
  output logic [4:0] day_bin,
  output logic       sec_tick,
  output logic       min_tick,
  output logic       hour_tick,
  output logic       day_tick,
  output logic       month_tick,
  output logic       year_tick,
  output logic       load_err
);

  localparam int unsigned PW = (DIV < 2) ? 1 : $clog2(DIV + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  // BCD +1 on a two-digit value; callers handle the field's own wrap point.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) bcd_inc = {v[7:4] + 4'd1, 4'd0};
    else                bcd_inc = {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Year divisible by 4, evaluated directly on the BCD digits.
  function automatic logic is_leap(input logic [7:0] y);
    if (y[4] == 1'b0) is_leap = (y[3:0] == 4'd0) || (y[3:0] == 4'd4) || (y[3:0] == 4'd8);
    else              is_leap = (y[3:0] == 4'd2) || (y[3:0] == 4'd6);
  endfunction

  // Last day of the month as BCD.
  function automatic logic [7:0] month_len(input logic [7:0] m, input logic [7:0] y);
    case (m)
      8'h02:                      month_len = (LEAP_EN && is_leap(y)) ? 8'h29 : 8'h28;
      8'h04, 8'h06, 8'h09, 8'h11: month_len = 8'h30;
      default:                    month_len = 8'h31;
    endcase
  endfunction

  function automatic logic bcd_ok(input logic [7:0] v);
    bcd_ok = (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  logic [7:0]    sec_q, sec_d, min_q, min_d, hour_q, hour_d;
  logic [7:0]    day_q, day_d, month_q, month_d, year_q, year_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          sec_tick_q, sec_tick_d, min_tick_q, min_tick_d;
  logic          hour_tick_q, hour_tick_d, day_tick_q, day_tick_d;
  logic          month_tick_q, month_tick_d, year_tick_q, year_tick_d;
  logic          load_err_q, load_err_d;
  logic          load_ok;
  logic          presc_wrap;
  logic [4:0]    hour12;

  // Load validation: every digit legal, every field in range, day within month.
  always_comb begin
    load_ok = bcd_ok(ld_sec) && bcd_ok(ld_min) && bcd_ok(ld_hour) &&
              bcd_ok(ld_day) && bcd_ok(ld_month) && bcd_ok(ld_year) &&
              (ld_sec <= 8'h59) && (ld_min <= 8'h59) && (ld_hour <= 8'h23) &&
              (ld_month >= 8'h01) && (ld_month <= 8'h12) &&
              (ld_day >= 8'h01) && (ld_day <= month_len(ld_month, ld_year));
  end

  // Next-state: load beats enable; an advance ripples carries up the fields.
  // Each *_tick marks that its field was stepped on this advance.
  always_comb begin
    sec_d        = sec_q;
    min_d        = min_q;
    hour_d       = hour_q;
    day_d        = day_q;
    month_d      = month_q;
    year_d       = year_q;
    presc_d      = presc_q;
    sec_tick_d   = 1'b0;
    min_tick_d   = 1'b0;
    hour_tick_d  = 1'b0;
    day_tick_d   = 1'b0;
    month_tick_d = 1'b0;
    year_tick_d  = 1'b0;
    load_err_d   = 1'b0;
    presc_wrap   = (presc_q == PRESC_LAST);

    if (load) begin
      if (load_ok) begin
        sec_d   = ld_sec;
        min_d   = ld_min;
        hour_d  = ld_hour;
        day_d   = ld_day;
        month_d = ld_month;
        year_d  = ld_year;
        presc_d = '0;
      end else begin
        load_err_d = 1'b1;
        // A rejected load keeps the prescaler cadence but never steps time.
        if (enable) presc_d = presc_wrap ? '0 : presc_q + PW'(1);
      end
    end else if (enable) begin
      presc_d = presc_wrap ? '0 : presc_q + PW'(1);
      if (presc_wrap) begin
        sec_tick_d = 1'b1;
        if (sec_q == 8'h59) begin
          sec_d      = 8'h00;
          min_tick_d = 1'b1;
          if (min_q == 8'h59) begin
            min_d       = 8'h00;
            hour_tick_d = 1'b1;
            if (hour_q == 8'h23) begin
              hour_d     = 8'h00;
              day_tick_d = 1'b1;
              if (day_q == month_len(month_q, year_q)) begin
                day_d        = 8'h01;
                month_tick_d = 1'b1;
                if (month_q == 8'h12) begin
                  month_d     = 8'h01;
                  year_tick_d = 1'b1;
                  year_d      = (year_q == 8'h99) ? 8'h00 : bcd_inc(year_q);
                end else begin
                  month_d = bcd_inc(month_q);
                end
              end else begin
                day_d = bcd_inc(day_q);
              end
            end else begin
              hour_d = bcd_inc(hour_q);
            end
          end else begin
            min_d = bcd_inc(min_q);
          end
        end else begin
          sec_d = bcd_inc(sec_q);
        end
      end
    end
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      sec_q        <= 8'h00;
      min_q        <= 8'h00;
      hour_q       <= 8'h00;
      day_q        <= 8'h01;
      month_q      <= 8'h01;
      year_q       <= 8'h00;
      presc_q      <= '0;
      sec_tick_q   <= 1'b0;
      min_tick_q   <= 1'b0;
      hour_tick_q  <= 1'b0;
      day_tick_q   <= 1'b0;
      month_tick_q <= 1'b0;
      year_tick_q  <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      sec_q        <= sec_d;
      min_q        <= min_d;
      hour_q       <= hour_d;
      day_q        <= day_d;
      month_q      <= month_d;
      year_q       <= year_d;
      presc_q      <= presc_d;
      sec_tick_q   <= sec_tick_d;
      min_tick_q   <= min_tick_d;
      hour_tick_q  <= hour_tick_d;
      day_tick_q   <= day_tick_d;
      month_tick_q <= month_tick_d;
      year_tick_q  <= year_tick_d;
      load_err_q   <= load_err_d;
    end
  end

  // Binary views and 12/24-hour display, decoded straight from the registers.
  always_comb begin
    min_bin  = 6'({2'b00, min_q[7:4]}) * 6'd10 + 6'({2'b00, min_q[3:0]});
    hour_bin = 5'({1'b0, hour_q[7:4]}) * 5'd10 + 5'({1'b0, hour_q[3:0]});
    day_bin  = 5'({1'b0, day_q[7:4]}) * 5'd10 + 5'({1'b0, day_q[3:0]});
    pm       = (hour_bin >= 5'd12);
    if (hour_bin == 5'd0)       hour12 = 5'd12;
    else if (hour_bin <= 5'd12) hour12 = hour_bin;
    else                        hour12 = hour_bin - 5'd12;
    if (mode24)                 hour_bcd = hour_q;
    else if (hour12 >= 5'd10)   hour_bcd = {4'd1, 4'(hour12 - 5'd10)};
    else                        hour_bcd = {4'd0, 4'(hour12)};
  end

  assign sec_bcd    = sec_q;
  assign min_bcd    = min_q;
  assign day_bcd    = day_q;
  assign month_bcd  = month_q;
  assign year_bcd   = year_q;
  assign sec_tick   = sec_tick_q;
  assign min_tick   = min_tick_q;
  assign hour_tick  = hour_tick_q;
  assign day_tick   = day_tick_q;
  assign month_tick = month_tick_q;
  assign year_tick  = year_tick_q;
  assign load_err   = load_err_q;

endmodule

// File: tb/tb_bcd_calendar_counter.sv
// Directed bench: three instances (DIV=1, DIV=4, DIV=1 without leap years)
// share one stimulus stream; each scenario task checks its own results.
module tb_bcd_calendar_counter;

  logic       clock = 1'b0;
  logic       reset, enable, mode24, load;
  logic [7:0] ld_sec, ld_min, ld_hour, ld_day, ld_month, ld_year;

  logic [7:0] sec_bcd [3], min_bcd [3], hour_bcd [3], day_bcd [3], month_bcd [3], year_bcd [3];
  logic       pm [3];
  logic [5:0] min_bin [3];
  logic [4:0] hour_bin [3], day_bin [3];
  logic       sec_tick [3], min_tick [3], hour_tick [3], day_tick [3], month_tick [3], year_tick [3];
  logic       load_err [3];

  // {hour(24h view only when mode24=1), min, sec, day, month, year} and tick vector
  logic [47:0] tod [3];
  logic [5:0]  tk  [3];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    bcd_calendar_counter #(
      .DIV    ((g == 1) ? 4 : 1),
      .LEAP_EN((g == 2) ? 1'b0 : 1'b1)
    ) u_dut (
      .clock     (clock),
      .reset     (reset),
      .enable    (enable),
      .mode24    (mode24),
      .load      (load),
      .ld_sec    (ld_sec),
      .ld_min    (ld_min),
      .ld_hour   (ld_hour),
      .ld_day    (ld_day),
      .ld_month  (ld_month),
      .ld_year   (ld_year),
      .sec_bcd   (sec_bcd[g]),
      .min_bcd   (min_bcd[g]),
      .hour_bcd  (hour_bcd[g]),
      .day_bcd   (day_bcd[g]),
      .month_bcd (month_bcd[g]),
      .year_bcd  (year_bcd[g]),
      .pm        (pm[g]),
      .min_bin   (min_bin[g]),
      .hour_bin  (hour_bin[g]),
      .day_bin   (day_bin[g]),
      .sec_tick  (sec_tick[g]),
      .min_tick  (min_tick[g]),
      .hour_tick (hour_tick[g]),
      .day_tick  (day_tick[g]),
      .month_tick(month_tick[g]),
      .year_tick (year_tick[g]),
      .load_err  (load_err[g])
    );
    assign tod[g] = {hour_bcd[g], min_bcd[g], sec_bcd[g], day_bcd[g], month_bcd[g], year_bcd[g]};
    assign tk[g]  = {sec_tick[g], min_tick[g], hour_tick[g], day_tick[g], month_tick[g], year_tick[g]};
  end

  // One clock edge; outputs are then sampled 1 time unit later.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                         input logic [7:0] d, input logic [7:0] mo, input logic [7:0] y);
    ld_hour = h; ld_min = m; ld_sec = s; ld_day = d; ld_month = mo; ld_year = y;
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; load = 1'b0; mode24 = 1'b1;
    ld_sec = 8'h00; ld_min = 8'h00; ld_hour = 8'h00; ld_day = 8'h01; ld_month = 8'h01; ld_year = 8'h00;
    step(); step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (tod[i] !== 48'h000000_010100) begin
        errors++; $display("FAIL reset_tod[%0d] got %h want 000000010100", i, tod[i]);
      end
      checks++;
      if ({tk[i], load_err[i], pm[i]} !== 8'b0) begin
        errors++; $display("FAIL reset_pulses[%0d] got %b want 00000000", i, {tk[i], load_err[i], pm[i]});
      end
      checks++;
      if ({min_bin[i], hour_bin[i], day_bin[i]} !== {6'd0, 5'd0, 5'd1}) begin
        errors++; $display("FAIL reset_bin[%0d] got %0d/%0d/%0d want 0/0/1", i, min_bin[i], hour_bin[i], day_bin[i]);
      end
    end
  endtask

  task automatic test_seconds();
    enable = 1'b1;
    for (int n = 0; n < 59; n++) step();
    checks++;
    if ({min_bcd[0], sec_bcd[0], tk[0]} !== {8'h00, 8'h59, 6'b100000}) begin
      errors++; $display("FAIL sec59 got min %h sec %h tk %b want 00 59 100000", min_bcd[0], sec_bcd[0], tk[0]);
    end
    step();
    checks++;
    if ({min_bcd[0], sec_bcd[0], tk[0], min_bin[0]} !== {8'h01, 8'h00, 6'b110000, 6'd1}) begin
      errors++; $display("FAIL sec60 got min %h sec %h tk %b minbin %0d want 01 00 110000 1",
                         min_bcd[0], sec_bcd[0], tk[0], min_bin[0]);
    end
    checks++;
    if ({min_bcd[1], sec_bcd[1]} !== 16'h0015) begin
      errors++; $display("FAIL div4_60en got %h want 0015", {min_bcd[1], sec_bcd[1]});
    end
    enable = 1'b0;
    step();
    checks++;
    if ({min_bcd[0], sec_bcd[0], tk[0]} !== {8'h01, 8'h00, 6'b000000}) begin
      errors++; $display("FAIL hold got min %h sec %h tk %b want 01 00 000000", min_bcd[0], sec_bcd[0], tk[0]);
    end
  endtask

  task automatic test_prescaler();
    reset = 1'b1; step(); reset = 1'b0;
    enable = 1'b1;
    for (int n = 0; n < 7; n++) step();
    checks++;
    if ({sec_bcd[1], sec_bcd[0]} !== 16'h0107) begin
      errors++; $display("FAIL div4_7en got %h want 0107", {sec_bcd[1], sec_bcd[0]});
    end
    step();
    checks++;
    if ({sec_bcd[1], sec_tick[1]} !== {8'h02, 1'b1}) begin
      errors++; $display("FAIL div4_8en got sec %h tick %b want 02 1", sec_bcd[1], sec_tick[1]);
    end
    enable = 1'b0;
  endtask

  task automatic test_leap();
    do_load(8'h23, 8'h59, 8'h59, 8'h28, 8'h02, 8'h24);
    checks++;
    if ({tod[0], tk[0], load_err[0]} !== {48'h235959_280224, 7'b0}) begin
      errors++; $display("FAIL load_leap got %h tk %b err %b want 235959280224", tod[0], tk[0], load_err[0]);
    end
    enable = 1'b1; step(); enable = 1'b0;
    checks++;
    if ({tod[0], tk[0]} !== {48'h000000_290224, 6'b111100}) begin
      errors++; $display("FAIL feb29 got %h tk %b want 000000290224 111100", tod[0], tk[0]);
    end
    checks++;
    if ({tod[2], tk[2]} !== {48'h000000_010324, 6'b111110}) begin
      errors++; $display("FAIL noleap got %h tk %b want 000000010324 111110", tod[2], tk[2]);
    end
    checks++;
    if ({tod[1], tk[1]} !== {48'h235959_280224, 6'b0}) begin
      errors++; $display("FAIL div4_load_clr got %h tk %b want 235959280224 000000", tod[1], tk[1]);
    end
    do_load(8'h23, 8'h59, 8'h59, 8'h28, 8'h02, 8'h23);
    enable = 1'b1; step(); enable = 1'b0;
    checks++;
    if ({tod[0], tk[0]} !== {48'h000000_010323, 6'b111110}) begin
      errors++; $display("FAIL mar01 got %h tk %b want 000000010323 111110", tod[0], tk[0]);
    end
  endtask

  task automatic test_year_wrap();
    do_load(8'h23, 8'h59, 8'h59, 8'h31, 8'h12, 8'h99);
    enable = 1'b1; step(); enable = 1'b0;
    checks++;
    if ({tod[0], tk[0]} !== {48'h000000_010100, 6'b111111}) begin
      errors++; $display("FAIL year_wrap got %h tk %b want 000000010100 111111", tod[0], tk[0]);
    end
    step();
    checks++;
    if (tk[0] !== 6'b0) begin
      errors++; $display("FAIL tick_drop got %b want 000000", tk[0]);
    end
  endtask

  task automatic test_load_err();
    do_load(8'h10, 8'h20, 8'h30, 8'h31, 8'h04, 8'h05);
    checks++;
    if ({load_err[0], tod[0]} !== {1'b1, 48'h000000_010100}) begin
      errors++; $display("FAIL apr31 got err %b tod %h want 1 000000010100", load_err[0], tod[0]);
    end
    step();
    checks++;
    if (load_err[0] !== 1'b0) begin
      errors++; $display("FAIL err_drop got %b want 0", load_err[0]);
    end
    do_load(8'h10, 8'h5A, 8'h30, 8'h01, 8'h04, 8'h05);
    checks++;
    if ({load_err[0], tod[0]} !== {1'b1, 48'h000000_010100}) begin
      errors++; $display("FAIL min5A got err %b tod %h want 1 000000010100", load_err[0], tod[0]);
    end
    do_load(8'h10, 8'h20, 8'h30, 8'h00, 8'h04, 8'h05);
    checks++;
    if (load_err[0] !== 1'b1) begin
      errors++; $display("FAIL day00 got %b want 1", load_err[0]);
    end
    do_load(8'h10, 8'h20, 8'h30, 8'h29, 8'h02, 8'h24);
    checks++;
    if ({load_err[0], tod[0], load_err[2], tod[2]} !== {1'b0, 48'h102030_290224, 1'b1, 48'h000000_010100}) begin
      errors++; $display("FAIL feb29_load got leap %b %h noleap %b %h want 0 102030290224 1 000000010100",
                         load_err[0], tod[0], load_err[2], tod[2]);
    end
  endtask

  logic [7:0] hd_in   [5] = '{8'h00, 8'h12, 8'h13, 8'h11, 8'h23};
  logic [7:0] hd_12   [5] = '{8'h12, 8'h12, 8'h01, 8'h11, 8'h11};
  logic       hd_pm   [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [4:0] hd_bin  [5] = '{5'd0, 5'd12, 5'd13, 5'd11, 5'd23};

  task automatic test_hour_display();
    for (int i = 0; i < 5; i++) begin
      do_load(hd_in[i], 8'h00, 8'h00, 8'h15, 8'h06, 8'h10);
      mode24 = 1'b0; #1;
      checks++;
      if ({hour_bcd[0], pm[0], hour_bin[0]} !== {hd_12[i], hd_pm[i], hd_bin[i]}) begin
        errors++; $display("FAIL h12_%h got %h pm %b bin %0d want %h pm %b bin %0d",
                           hd_in[i], hour_bcd[0], pm[0], hour_bin[0], hd_12[i], hd_pm[i], hd_bin[i]);
      end
      mode24 = 1'b1; #1;
      checks++;
      if ({hour_bcd[0], pm[0], hour_bin[0]} !== {hd_in[i], hd_pm[i], hd_bin[i]}) begin
        errors++; $display("FAIL h24_%h got %h pm %b bin %0d want %h pm %b bin %0d",
                           hd_in[i], hour_bcd[0], pm[0], hour_bin[0], hd_in[i], hd_pm[i], hd_bin[i]);
      end
    end
  endtask

  task automatic test_priority();
    enable = 1'b1;
    do_load(8'h01, 8'h02, 8'h10, 8'h05, 8'h07, 8'h33);
    checks++;
    if ({tod[0], tk[0], day_bin[0]} !== {48'h010210_050733, 6'b0, 5'd5}) begin
      errors++; $display("FAIL load_over_en got %h tk %b daybin %0d want 010210050733 000000 5",
                         tod[0], tk[0], day_bin[0]);
    end
    step();
    checks++;
    if ({sec_bcd[0], sec_tick[0]} !== {8'h11, 1'b1}) begin
      errors++; $display("FAIL en_after_load got %h tick %b want 11 1", sec_bcd[0], sec_tick[0]);
    end
    reset = 1'b1;
    do_load(8'h05, 8'h05, 8'h05, 8'h05, 8'h05, 8'h05);
    reset = 1'b0; enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({tod[i], tk[i], load_err[i]} !== {48'h000000_010100, 7'b0}) begin
        errors++; $display("FAIL reset_prio[%0d] got %h tk %b err %b want 000000010100", i, tod[i], tk[i], load_err[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_seconds();
    test_prescaler();
    test_leap();
    test_year_wrap();
    test_load_err();
    test_hour_display();
    test_priority();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_calendar_counter.md
Name: bcd_calendar_counter

Overview:
Parametrised BCD time-of-day and calendar counter: seconds, minutes, hours, day-of-month, month and two-digit year.
- Adds a tick prescaler, runtime 12/24-hour display, true month lengths with leap-year February, a validated parallel load, and per-field rollover pulses.
- Sits between the board tick generator and the display/alarm logic, and supplies consistent BCD and binary views of the time.

Parameters:
DIV, 1, number of enable pulses per one-second advance (1..65535); prescaler width is clog2(DIV+1), minimum 1.
LEAP_EN, 1, 1 = February has 29 days when year % 4 == 0 (year 00 counts as leap); 0 = February always has 28 days.

Ports:
clock  in  1  system clock
reset  in  1  reset, synchronous, active-high
enable  in  1  tick strobe; every DIV-th enabled cycle advances one second
mode24  in  1  1 = 24-hour hour_bcd; 0 = 12-hour hour_bcd plus pm
load  in  1  one-cycle set strobe
ld_sec, ld_min  in  8  BCD {tens,ones} load values
ld_hour  in  8  BCD, always 24-hour format (00..23)
ld_day, ld_month, ld_year  in  8  BCD load values
sec_bcd, min_bcd, day_bcd, month_bcd, year_bcd  out  8  BCD {tens,ones}
hour_bcd  out  8  BCD hour in the display format selected by mode24
pm  out  1  1 when internal hour >= 12 (valid in both modes)
min_bin  out  6  binary minutes 0..59
hour_bin  out  5  binary internal 24-hour hour 0..23
day_bin  out  5  binary day 1..31
sec_tick, min_tick, hour_tick, day_tick, month_tick, year_tick  out  1  one-cycle rollover pulses
load_err  out  1  one-cycle pulse: load rejected

Behaviour:
- Reset values: 00:00:00, day 01, month 01, year 00, prescaler 0, all pulses 0, load_err 0, pm 0. Binary outputs 0/0/1.
- Priority in any cycle: reset > load > enable.
- Prescaler: counts enabled cycles 0..DIV-1. The cycle with enable=1 and prescaler==DIV-1 is the advance cycle; the prescaler returns to 0. With DIV=1 every enabled cycle advances.
- Advance order and wrap:
  - sec 59->00 carries into min.
  - min 59->00 carries into hour.
  - hour 23->00 carries into day.
  - day last->01 carries into month.
  - month 12->01 carries into year.
  - year 99->00.
- Month length:
  - 31 days: months 1,3,5,7,8,10,12.
  - 30 days: months 4,6,9,11.
  - February: 28 days, or 29 if LEAP_EN and year%4==0. Leap test on BCD: tens even and ones in {0,4,8}, or tens odd and ones in {2,6}.
- Tick pulses: registered, high for exactly the cycle after the advancing edge, i.e. concurrent with the wrapped register value. Example: at 23:59:59 on 31/12/99, one advance raises all six pulses together.
- Load:
  - Accepted only if every field is valid BCD (each nibble <= 9) and in range: sec/min <= 59, hour <= 23, month 1..12, year <= 99, day 1..length(ld_month, ld_year).
  - Accepted: all fields update next edge, prescaler clears to 0, no tick pulses.
  - Rejected: no state change, load_err high one cycle, prescaler continues only if enable.
  - A load coincident with enable drops that enable.
- Hour display:
  - hour_bcd and pm are combinational from the internal hour register and mode24. A mode24 change is visible the same cycle and never alters the internal count.
  - 12-hour mapping: 0->12 (pm=0), 1..11->same, 12->12 (pm=1), 13..23->01..11 (pm=1).
- Binary outputs: derived from the same registers as the BCD outputs, never lagging them by a cycle.
- Reset mid-count: prescaler and all fields return to reset values the next edge, and any pending pulse is cleared.
- enable=0: all state holds, and pulses and load_err drop after one cycle.

Test Plan:
- Reset, DIV=1, 60 enables -> sec_bcd 00, min_bcd 01, min_tick high 1 cycle, sec_tick high 1 cycle.
- DIV=4: 7 enables -> sec_bcd 01, prescaler at 3; the 8th enable -> sec_bcd 02.
- Load 23:59:59 28/02/24, 1 enable -> 00:00:00 29/02/24, day_tick=1. Load same with year 23 -> 01/03/23, month_tick=1.
- Load 23:59:59 31/12/99, 1 enable -> 00:00:00 01/01/00, all six ticks high together.
- Load day 31 month 04 -> load_err=1, state unchanged. Load ld_min 8'h5A -> load_err=1.
- Internal hour 00, 12, 13 with mode24=0 -> hour_bcd 12/pm0, 12/pm1, 01/pm1. Then mode24=1 -> 00, 12, 13, hour_bin unchanged.
